// File: rtl/stage4_types_pkg.sv
// Shared types for the 4-stage pipeline front end.
// Holds the fetch-queue entry record and the NOP word shown when the queue is empty.
package stage4_types_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
        logic  fault;
        logic  mal;
    } fq_entry_t;

    // addi x0,x0,0
    localparam word_t FQ_NOP = 32'h0000_0013;

endpackage

// File: rtl/stage4_fetch_queue_if.sv
// Fetch-queue bundle: fetch enqueue side, hazard controls and the head-of-queue view.
// The queue itself uses the slave modport; fetch/hazard logic uses master.
interface stage4_fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    import stage4_types_pkg::*;

    logic                   enq_valid;
    word_t                  enq_instr;
    word_t                  enq_pc;
    logic                   enq_fault;
    logic                   enq_mal;
    logic                   stall_queue;
    logic                   flush_queue;
    logic                   is_queue_full;
    logic                   deq_valid;
    word_t                  deq_instr;
    word_t                  deq_pc;
    logic                   deq_fault;
    logic                   deq_mal;
    logic                   valid_decode;
    word_t                  pc_decode;
    logic [$clog2(DEPTH):0] count;

    modport master (
        output enq_valid, enq_instr, enq_pc, enq_fault, enq_mal, stall_queue, flush_queue,
        input  is_queue_full, deq_valid, deq_instr, deq_pc, deq_fault, deq_mal,
        input  valid_decode, pc_decode, count
    );

    modport slave (
        input  enq_valid, enq_instr, enq_pc, enq_fault, enq_mal, stall_queue, flush_queue,
        output is_queue_full, deq_valid, deq_instr, deq_pc, deq_fault, deq_mal,
        output valid_decode, pc_decode, count
    );

endinterface

// File: rtl/stage4_fetch_queue.sv
// First-word-fall-through instruction queue between fetch and decode.
// Head entry is presented combinationally; flush beats everything, a full queue drops enqueues.
module stage4_fetch_queue
    import stage4_types_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter word_t       NOP_INSN = FQ_NOP
) (
    input logic                 clk,
    input logic                 rst,
    stage4_fetch_queue_if.slave fq
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    fq_entry_t             mem_q [DEPTH];
    fq_entry_t             mem_d [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [PtrW-1:0]       head_q, head_d;
    logic [PtrW-1:0]       tail_q, tail_d;
    logic [CntW-1:0]       count_q, count_d;

    logic      full;
    logic      not_empty;
    logic      enq_fire;
    logic      deq_fire;
    fq_entry_t head_entry;

    always_comb begin
        full      = (count_q == CntW'(DEPTH));
        not_empty = (count_q != '0);
        // Full test uses this cycle's count: no bypass even if the head leaves now.
        enq_fire  = fq.enq_valid && !full && !fq.flush_queue;
        deq_fire  = not_empty && !fq.stall_queue && !fq.flush_queue;

        mem_d   = mem_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (fq.flush_queue) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) begin
                mem_d[tail_q]   = '{instr: fq.enq_instr, pc: fq.enq_pc,
                                    fault: fq.enq_fault, mal: fq.enq_mal};
                valid_d[tail_q] = 1'b1;
                tail_d          = tail_q + PtrW'(1);
            end
            if (deq_fire) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + PtrW'(1);
            end
            count_d = count_q + CntW'(enq_fire) - CntW'(deq_fire);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        head_entry = mem_q[head_q];
        if (!not_empty) begin
            head_entry = '{instr: NOP_INSN, pc: '0, fault: 1'b0, mal: 1'b0};
        end
    end

    assign fq.is_queue_full = full;
    assign fq.deq_valid     = not_empty;
    assign fq.deq_instr     = head_entry.instr;
    assign fq.deq_pc        = head_entry.pc;
    assign fq.deq_fault     = head_entry.fault;
    assign fq.deq_mal       = head_entry.mal;
    assign fq.valid_decode  = not_empty;
    assign fq.pc_decode     = head_entry.pc;
    assign fq.count         = count_q;

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= CntW'(DEPTH));
    a_no_deq_empty: assert property (@(posedge clk) disable iff (rst) !(deq_fire && !not_empty));
    a_head_valid: assert property (@(posedge clk) disable iff (rst) valid_q[head_q] == not_empty);

endmodule

// File: tb/tb_stage4_fetch_queue.sv
// Self-checking bench for stage4_fetch_queue: table of single-cycle vectors with hand-derived
// expectations, plus a scoreboard model checked every cycle and hand sequences for corners.
module tb_stage4_fetch_queue;
    import stage4_types_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stage4_fetch_queue_if #(.DEPTH(DEPTH)) fq ();

    stage4_fetch_queue #(.DEPTH(DEPTH), .NOP_INSN(FQ_NOP)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (fq.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int dut_drops = 0;

    fq_entry_t model_q[$];

    typedef struct {
        logic        enq_v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        stall;
        logic [31:0] exp_count;
        logic        exp_valid;
        logic        exp_full;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare DUT head against the model, then advance the model and clock one edge.
    task automatic step(input logic enq_v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic fault, input logic mal, input logic stall,
                        input logic flush);
        fq_entry_t exp_head;
        logic      accept;
        logic      pop;
        fq.enq_valid   = enq_v;
        fq.enq_instr   = instr;
        fq.enq_pc      = pc;
        fq.enq_fault   = fault;
        fq.enq_mal     = mal;
        fq.stall_queue = stall;
        fq.flush_queue = flush;
        #1;
        exp_head = '{instr: FQ_NOP, pc: '0, fault: 1'b0, mal: 1'b0};
        if (model_q.size() != 0) exp_head = model_q[0];
        chk("sb_count", 32'(fq.count), 32'(model_q.size()));
        chk("sb_valid", 32'(fq.deq_valid), 32'(model_q.size() != 0));
        chk("sb_valid_decode", 32'(fq.valid_decode), 32'(model_q.size() != 0));
        chk("sb_full", 32'(fq.is_queue_full), 32'(model_q.size() == DEPTH));
        chk("sb_instr", fq.deq_instr, exp_head.instr);
        chk("sb_pc", fq.deq_pc, exp_head.pc);
        chk("sb_pc_decode", fq.pc_decode, exp_head.pc);
        chk("sb_flags", {30'd0, fq.deq_fault, fq.deq_mal}, {30'd0, exp_head.fault, exp_head.mal});
        if (enq_v && fq.is_queue_full) dut_drops++;
        accept = enq_v && (model_q.size() < DEPTH) && !flush;
        pop    = (model_q.size() != 0) && !stall && !flush;
        if (flush) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (accept) model_q.push_back('{instr: instr, pc: pc, fault: fault, mal: mal});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{1, 32'h00500093, 32'h200, 0, 1, 1, 0, 32'h00500093, 32'h200};
        vecs[1] = '{1, 32'h00100113, 32'h204, 1, 2, 1, 0, 32'h00500093, 32'h200};
        vecs[2] = '{1, 32'h00200193, 32'h208, 1, 3, 1, 0, 32'h00500093, 32'h200};
        vecs[3] = '{1, 32'h00300213, 32'h20C, 1, 4, 1, 1, 32'h00500093, 32'h200};
        vecs[4] = '{1, 32'h00400293, 32'h210, 1, 4, 1, 1, 32'h00500093, 32'h200};
        // Full with enq+deq: enqueue rejected, count 4 -> 3.
        vecs[5] = '{1, 32'h00400293, 32'h210, 0, 3, 1, 0, 32'h00100113, 32'h204};
        // Not full with enq+deq: count holds, order kept.
        vecs[6] = '{1, 32'h00500313, 32'h214, 0, 3, 1, 0, 32'h00200193, 32'h208};
        vecs[7] = '{0, 32'h0,        32'h0,   0, 2, 1, 0, 32'h00300213, 32'h20C};
        vecs[8] = '{0, 32'h0,        32'h0,   0, 1, 1, 0, 32'h00500313, 32'h214};
        vecs[9] = '{0, 32'h0,        32'h0,   0, 0, 0, 0, 32'h00000013, 32'h0};

        fq.enq_valid   = 1'b0;
        fq.enq_instr   = '0;
        fq.enq_pc      = '0;
        fq.enq_fault   = 1'b0;
        fq.enq_mal     = 1'b0;
        fq.stall_queue = 1'b0;
        fq.flush_queue = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(fq.deq_valid), 32'd0);
        chk("rst_instr", fq.deq_instr, 32'h13);
        chk("rst_pc", fq.deq_pc, 32'h0);
        chk("rst_full", 32'(fq.is_queue_full), 32'd0);
        chk("rst_count", 32'(fq.count), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].enq_v, vecs[i].instr, vecs[i].pc, 1'b0, 1'b0, vecs[i].stall, 1'b0);
            chk($sformatf("vec%0d_count", i), 32'(fq.count), vecs[i].exp_count);
            chk($sformatf("vec%0d_valid", i), 32'(fq.deq_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_full", i), 32'(fq.is_queue_full), 32'(vecs[i].exp_full));
            chk($sformatf("vec%0d_instr", i), fq.deq_instr, vecs[i].exp_instr);
            chk($sformatf("vec%0d_pc", i), fq.pc_decode, vecs[i].exp_pc);
        end
        chk("drops_seen", 32'(dut_drops), 32'd2);

        // Flush with a same-cycle enqueue discards everything.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h00A00013 + 32'(i), 32'h400 + 32'(4 * i),
                                         1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h00B00013, 32'h40C, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("flush_count", 32'(fq.count), 32'd0);
        chk("flush_valid", 32'(fq.deq_valid), 32'd0);
        chk("flush_instr", fq.deq_instr, 32'h13);
        step(1'b1, 32'h00C00013, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_flush_head", fq.deq_pc, 32'h500);
        idle(2);

        // Fault flags travel with their entry and clear behind it.
        step(1'b1, 32'h00D00013, 32'h300, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("fault_set", 32'(fq.deq_fault), 32'd1);
        chk("mal_set", 32'(fq.deq_mal), 32'd1);
        chk("fault_pc", fq.pc_decode, 32'h300);
        step(1'b1, 32'h00E00013, 32'h304, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fault_clear", {30'd0, fq.deq_fault, fq.deq_mal}, 32'd0);
        chk("fault_next_pc", fq.pc_decode, 32'h304);
        idle(2);

        // Ten enq/deq pairs so both pointers wrap several times.
        step(1'b1, 32'h10000013, 32'h600, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 32'h10000013 + 32'(i), 32'h600 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("wrap_head", fq.deq_pc, 32'h628);
        idle(2);

        // Async reset mid-stream clears outputs before any clock edge.
        step(1'b1, 32'h20000013, 32'h700, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h20000017, 32'h704, 1'b0, 1'b0, 1'b1, 1'b0);
        fq.enq_valid   = 1'b0;
        fq.stall_queue = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(fq.deq_valid), 32'd0);
        chk("arst_count", 32'(fq.count), 32'd0);
        chk("arst_instr", fq.deq_instr, 32'h13);
        chk("arst_pc", fq.pc_decode, 32'h0);
        #1;
        rst = 1'b0;
        model_q.delete();
        @(posedge clk);
        #1;
        step(1'b1, 32'h30000013, 32'h800, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
